pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the fetch/decode/execute front end. It combines the decode-stage hazard, branch, fence and trap indications into hold, flush and redirect controls for the fe2de and de2ex pipeline registers and for the fetch PC. A small state machine sequences FENCE draining and trap/mret redirects. A saturating counter records stall cycles for performance monitoring.

---
 rtl/pipe_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: fetch/decode/execute front-end sequencing controller.
// Combines decode hazard, branch, fence and trap indications into hold,
// flush and redirect controls for fe2de, de2ex and the fetch PC.
// Optional build macro: FENCE_REFETCH_EN (FENCE exit redirects to the
// instruction after the FENCE and flushes fe2de to drop stale prefetch).
//
// state | meaning
// RUN   | normal issue; stall / trap / branch / fence arbitration
// FENCE | draining memory and execute before the FENCE completes
// TRAP  | single redirect cycle to mtvec (ECALL/EBREAK) or mepc (MRET)
module pipe_ctrl #(
    parameter int FENCE_TIMEOUT = 255,
    parameter int STALL_CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   de2ex_inst_valid,
    input  logic                   de_stall,
    input  logic                   de_store_load_conflict,
    input  logic                   ex_md_busy,
    input  logic                   lsu_idle,
    input  logic                   branch_predict_err,
    input  logic [31:0]            de2fe_branch_target,
    input  logic                   de2ex_fence_stall,
    input  logic                   de2ex_exp,
    input  logic                   de2ex_mret,
    input  logic [31:0]            de2ex_pc,
    input  logic                   fe2de_rv16_ffout,
    input  logic [31:0]            mtvec,
    input  logic [31:0]            mepc,
    output logic                   fe2de_hold,
    output logic                   fe2de_flush,
    output logic                   de2ex_flush,
    output logic                   fe_redirect,
    output logic [31:0]            fe_redirect_pc,
    output logic                   fence_busy,
    output logic                   fence_timeout,
    output logic [1:0]             ctrl_state,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int DRAIN_W = (FENCE_TIMEOUT < 2) ? 1 : $clog2(FENCE_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FENCE = 2'd1,
        ST_TRAP  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_is_mret;
    logic [31:0]            r_fence_pc;
    logic [DRAIN_W-1:0]     r_drain_cnt;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic        w_stall;
    logic        w_trap;
    logic        w_fence;
    logic        w_drained;
    logic        w_at_limit;
    logic        w_hold;
    logic        w_fe_flush;
    logic        w_de_flush;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic        w_busy;
    logic        w_timeout;
    logic        w_latch_trap;
    logic        w_latch_fence;

    assign w_stall    = de_stall | de_store_load_conflict | ex_md_busy;
    assign w_trap     = de2ex_inst_valid & (de2ex_exp | de2ex_mret);
    assign w_fence    = de2ex_inst_valid & de2ex_fence_stall;
    assign w_drained  = lsu_idle & ~ex_md_busy;
    assign w_at_limit = (r_drain_cnt == DRAIN_W'(FENCE_TIMEOUT));

    // Next-state and control outputs from registered state plus live inputs.
    always_comb begin
        w_state_nxt   = r_state;
        w_hold        = 1'b0;
        w_fe_flush    = 1'b0;
        w_de_flush    = 1'b0;
        w_redirect    = 1'b0;
        w_redirect_pc = 32'd0;
        w_busy        = 1'b0;
        w_timeout     = 1'b0;
        w_latch_trap  = 1'b0;
        w_latch_fence = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_stall) begin
                    w_hold     = 1'b1;
                    w_de_flush = 1'b1;
                end else if (w_trap) begin
                    w_fe_flush   = 1'b1;
                    w_latch_trap = 1'b1;
                    w_state_nxt  = ST_TRAP;
                end else if (branch_predict_err) begin
                    w_redirect    = 1'b1;
                    w_redirect_pc = de2fe_branch_target;
                    w_fe_flush    = 1'b1;
                end else if (w_fence) begin
                    w_hold        = 1'b1;
                    w_latch_fence = 1'b1;
                    w_state_nxt   = ST_FENCE;
                end
            end
            ST_TRAP: begin
                w_redirect    = 1'b1;
                w_redirect_pc = r_is_mret ? mepc : mtvec;
                w_fe_flush    = 1'b1;
                w_de_flush    = 1'b1;
                w_state_nxt   = ST_RUN;
            end
            ST_FENCE: begin
                w_busy     = 1'b1;
                w_de_flush = 1'b1;
                w_timeout  = w_at_limit;
                if (w_drained || w_at_limit) begin
                    w_state_nxt = ST_RUN;
`ifdef FENCE_REFETCH_EN
                    w_redirect    = 1'b1;
                    w_redirect_pc = r_fence_pc;
                    w_fe_flush    = 1'b1;
`endif
                end else begin
                    w_hold = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign fe2de_hold     = w_hold;
    assign fe2de_flush    = w_fe_flush & ~w_hold;
    assign de2ex_flush    = w_de_flush;
    assign fe_redirect    = w_redirect;
    assign fe_redirect_pc = w_redirect_pc;
    assign fence_busy     = w_busy;
    assign fence_timeout  = w_timeout;
    assign ctrl_state     = r_state;
    assign stall_cnt      = r_stall_cnt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Trap flavour and FENCE return PC, captured as decode hands them over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_mret  <= 1'b0;
            r_fence_pc <= 32'd0;
        end else begin
            if (w_latch_trap) begin
                r_is_mret <= de2ex_mret;
            end
            if (w_latch_fence) begin
                r_fence_pc <= de2ex_pc + (fe2de_rv16_ffout ? 32'd2 : 32'd4);
            end
        end
    end

    // Drain counter: cleared on FENCE entry, counts each FENCE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drain_cnt <= '0;
        end else if (w_latch_fence) begin
            r_drain_cnt <= '0;
        end else if ((r_state == ST_FENCE) && !w_at_limit) begin
            r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
        end
    end

    // Saturating count of held fetch cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_hold && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: constant-expectation vectors, directed
// multi-cycle sequences and randomized traffic against a reference model.
module tb_pipe_ctrl;

    localparam int FTO = 8;
    localparam int SW  = 6;
    localparam int SMAX = (1 << SW) - 1;

    typedef struct {
        bit          ld, slc, md, lsu, bpe, valid, exp, mret, fence, rv16;
        logic [31:0] tgt, pc, mtvec, mepc;
    } in_t;

    typedef struct {
        bit          hold, fflush, dflush, redir, busy, tmo;
        logic [1:0]  st;
        logic [31:0] rpc;
    } out_t;

    typedef struct {
        in_t         x;
        logic [7:0]  ctl;
        logic [31:0] rpc;
    } vec_t;

    logic clk, rst_n;
    logic de2ex_inst_valid, de_stall, de_store_load_conflict, ex_md_busy, lsu_idle;
    logic branch_predict_err, de2ex_fence_stall, de2ex_exp, de2ex_mret, fe2de_rv16_ffout;
    logic [31:0] de2fe_branch_target, de2ex_pc, mtvec, mepc;
    logic fe2de_hold, fe2de_flush, de2ex_flush, fe_redirect, fence_busy, fence_timeout;
    logic [31:0] fe_redirect_pc;
    logic [1:0]  ctrl_state;
    logic [SW-1:0] stall_cnt;

    int n_pass = 0;
    int n_total = 0;

    // reference model state
    bit          m_trap_pending;
    bit          m_trap_is_ret;
    int          m_fence_age;
    logic [31:0] m_fence_ret;
    int          m_stall;

    pipe_ctrl #(.FENCE_TIMEOUT(FTO), .STALL_CNT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .de2ex_inst_valid(de2ex_inst_valid), .de_stall(de_stall),
        .de_store_load_conflict(de_store_load_conflict), .ex_md_busy(ex_md_busy),
        .lsu_idle(lsu_idle), .branch_predict_err(branch_predict_err),
        .de2fe_branch_target(de2fe_branch_target), .de2ex_fence_stall(de2ex_fence_stall),
        .de2ex_exp(de2ex_exp), .de2ex_mret(de2ex_mret), .de2ex_pc(de2ex_pc),
        .fe2de_rv16_ffout(fe2de_rv16_ffout), .mtvec(mtvec), .mepc(mepc),
        .fe2de_hold(fe2de_hold), .fe2de_flush(fe2de_flush), .de2ex_flush(de2ex_flush),
        .fe_redirect(fe_redirect), .fe_redirect_pc(fe_redirect_pc),
        .fence_busy(fence_busy), .fence_timeout(fence_timeout),
        .ctrl_state(ctrl_state), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t idle();
        in_t x;
        x = '{default: 0};
        x.lsu   = 1'b1;
        x.mtvec = 32'h200;
        x.mepc  = 32'h80;
        return x;
    endfunction

    function automatic in_t mk(bit ld, bit slc, bit md, bit bpe, logic [31:0] tgt,
                               bit valid, bit exp, bit mret, bit fence);
        in_t x;
        x = idle();
        x.ld = ld; x.slc = slc; x.md = md; x.bpe = bpe; x.tgt = tgt;
        x.valid = valid; x.exp = exp; x.mret = mret; x.fence = fence;
        return x;
    endfunction

    task automatic drive(input in_t x);
        de_stall = x.ld; de_store_load_conflict = x.slc; ex_md_busy = x.md;
        lsu_idle = x.lsu; branch_predict_err = x.bpe; de2fe_branch_target = x.tgt;
        de2ex_inst_valid = x.valid; de2ex_exp = x.exp; de2ex_mret = x.mret;
        de2ex_fence_stall = x.fence; de2ex_pc = x.pc; fe2de_rv16_ffout = x.rv16;
        mtvec = x.mtvec; mepc = x.mepc;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    function automatic logic [7:0] act_ctl();
        return {fe2de_hold, fe2de_flush, de2ex_flush, fe_redirect,
                fence_busy, fence_timeout, ctrl_state};
    endfunction

    function automatic logic [7:0] pack(input out_t o);
        return {o.hold, o.fflush, o.dflush, o.redir, o.busy, o.tmo, o.st};
    endfunction

    task automatic model_reset();
        m_trap_pending = 0; m_trap_is_ret = 0;
        m_fence_age = -1; m_fence_ret = 32'd0; m_stall = 0;
    endtask

    // Expected outputs for this cycle given the pipeline situation.
    function automatic out_t model_out(input in_t x);
        out_t o;
        bit leave;
        o = '{default: 0};
        if (m_trap_pending) begin
            o.st = 2; o.redir = 1; o.fflush = 1; o.dflush = 1;
            o.rpc = m_trap_is_ret ? x.mepc : x.mtvec;
        end else if (m_fence_age >= 0) begin
            o.st = 1; o.busy = 1; o.dflush = 1;
            o.tmo = (m_fence_age == FTO);
            leave = (x.lsu && !x.md) || (m_fence_age == FTO);
            if (!leave) o.hold = 1;
`ifdef FENCE_REFETCH_EN
            else begin
                o.redir = 1; o.rpc = m_fence_ret; o.fflush = 1;
            end
`endif
        end else if (x.ld || x.slc || x.md) begin
            o.hold = 1; o.dflush = 1;
        end else if (x.valid && (x.exp || x.mret)) begin
            o.fflush = 1;
        end else if (x.bpe) begin
            o.redir = 1; o.rpc = x.tgt; o.fflush = 1;
        end else if (x.valid && x.fence) begin
            o.hold = 1;
        end
        return o;
    endfunction

    task automatic model_step(input in_t x, input out_t o);
        if (o.hold && m_stall < SMAX) m_stall++;
        if (m_trap_pending) begin
            m_trap_pending = 0;
        end else if (m_fence_age >= 0) begin
            if ((x.lsu && !x.md) || (m_fence_age == FTO)) m_fence_age = -1;
            else m_fence_age++;
        end else if (!(x.ld || x.slc || x.md)) begin
            if (x.valid && (x.exp || x.mret)) begin
                m_trap_pending = 1; m_trap_is_ret = x.mret;
            end else if (!x.bpe && x.valid && x.fence) begin
                m_fence_age = 0;
                m_fence_ret = x.pc + (x.rv16 ? 32'd2 : 32'd4);
            end
        end
    endtask

    // One clock: drive after the edge, sample mid-cycle, check against model.
    task automatic run_cycle(input in_t x, input string tag);
        out_t e;
        @(posedge clk);
        #1;
        drive(x);
        #3;
        e = model_out(x);
        chk({tag, " ctl"}, 64'(act_ctl()), 64'(pack(e)));
        chk({tag, " rpc"}, 64'(fe_redirect_pc), 64'(e.rpc));
        chk({tag, " stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
        model_step(x, e);
    endtask

    vec_t vt[$];

    initial begin
        in_t x;
        int busy_cnt;

        // constant-expectation single-cycle vectors, all issued from RUN
        vt.push_back('{mk(0,0,0,0,0,0,0,0,0),           8'b0000_0000, 32'h0});
        vt.push_back('{mk(1,0,0,0,0,0,0,0,0),           8'b1010_0000, 32'h0});
        vt.push_back('{mk(0,1,0,0,0,0,0,0,0),           8'b1010_0000, 32'h0});
        vt.push_back('{mk(0,0,1,0,0,0,0,0,0),           8'b1010_0000, 32'h0});
        vt.push_back('{mk(0,0,0,1,32'h124,0,0,0,0),     8'b0101_0000, 32'h124});
        vt.push_back('{mk(1,0,0,1,32'h124,0,0,0,0),     8'b1010_0000, 32'h0});
        vt.push_back('{mk(0,0,0,0,0,0,1,0,0),           8'b0000_0000, 32'h0});
        vt.push_back('{mk(0,0,0,0,0,0,0,1,0),           8'b0000_0000, 32'h0});
        vt.push_back('{mk(0,0,0,0,0,0,0,0,1),           8'b0000_0000, 32'h0});
        vt.push_back('{mk(0,0,1,0,0,1,0,0,1),           8'b1010_0000, 32'h0});
        vt.push_back('{mk(0,1,0,0,0,1,1,0,0),           8'b1010_0000, 32'h0});
        vt.push_back('{mk(0,0,0,1,32'hABCD_0010,1,0,0,1), 8'b0101_0000, 32'hABCD_0010});

        model_reset();
        rst_n = 1'b0;
        drive(idle());
        #12;
        chk("reset ctl", 64'(act_ctl()), 64'h0);
        chk("reset rpc", 64'(fe_redirect_pc), 64'h0);
        chk("reset stall_cnt", 64'(stall_cnt), 64'h0);
        #10 rst_n = 1'b1;

        // three stall cycles
        for (int i = 0; i < 3; i++) begin
            run_cycle(mk(1,0,0,0,0,0,0,0,0), "stall3");
            chk("stall3 hold", 64'({fe2de_hold, de2ex_flush, fe_redirect}), 64'b110);
        end
        run_cycle(idle(), "stall3 end");
        chk("stall3 hold released", 64'(fe2de_hold), 64'h0);
        chk("stall3 count", 64'(stall_cnt), 64'd3);

        foreach (vt[i]) begin
            run_cycle(vt[i].x, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d table ctl", i), 64'(act_ctl()), 64'(vt[i].ctl));
            chk($sformatf("vec%0d table rpc", i), 64'(fe_redirect_pc), 64'(vt[i].rpc));
        end

        // MRET then ECALL: redirect one cycle later
        run_cycle(mk(0,0,0,0,0,1,0,1,0), "mret");
        chk("mret accept", 64'({fe2de_flush, de2ex_flush, ctrl_state}), 64'b1000);
        run_cycle(idle(), "mret trap");
        chk("mret trap", 64'({ctrl_state, fe_redirect, fe2de_flush, de2ex_flush}), 64'b10111);
        chk("mret pc", 64'(fe_redirect_pc), 64'h80);
        run_cycle(idle(), "mret back");
        chk("mret back state", 64'(ctrl_state), 64'd0);
        run_cycle(mk(0,0,0,0,0,1,1,0,0), "ecall");
        run_cycle(idle(), "ecall trap");
        chk("ecall pc", 64'(fe_redirect_pc), 64'h200);
        chk("ecall state", 64'(ctrl_state), 64'd2);
        run_cycle(idle(), "ecall back");
        chk("ecall back state", 64'(ctrl_state), 64'd0);

        // FENCE at 0x1000, LSU busy for 4 drain cycles
        x = mk(0,0,0,0,0,1,0,0,1); x.pc = 32'h1000;
        run_cycle(x, "fence enter");
        chk("fence enter hold", 64'({fe2de_hold, fe2de_flush, ctrl_state}), 64'b1000);
        busy_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            x = idle(); x.lsu = 0;
            run_cycle(x, "fence drain");
            busy_cnt += fence_busy;
        end
        run_cycle(idle(), "fence exit");
        busy_cnt += fence_busy;
        chk("fence exit hold", 64'(fe2de_hold), 64'h0);
`ifdef FENCE_REFETCH_EN
        chk("fence exit redirect", 64'({fe_redirect, fe2de_flush}), 64'b11);
        chk("fence exit pc", 64'(fe_redirect_pc), 64'h1004);
`else
        chk("fence exit redirect", 64'({fe_redirect, fe2de_flush}), 64'b00);
`endif
        run_cycle(idle(), "fence done");
        busy_cnt += fence_busy;
        chk("fence busy cycles", 64'(busy_cnt), 64'd5);
        chk("fence done state", 64'(ctrl_state), 64'd0);

        // forced exit: LSU never idles; compressed FENCE at top of memory
        x = mk(0,0,0,0,0,1,0,0,1); x.pc = 32'hFFFF_FFFE; x.rv16 = 1;
        run_cycle(x, "tmo enter");
        for (int k = 0; k <= FTO; k++) begin
            x = idle(); x.lsu = 0;
            run_cycle(x, "tmo drain");
            chk($sformatf("tmo k%0d", k), 64'({fence_busy, fence_timeout}),
                64'({1'b1, (k == FTO)}));
        end
`ifdef FENCE_REFETCH_EN
        chk("tmo wrap pc", 64'(fe_redirect_pc), 64'h0);
`endif
        x = idle(); x.lsu = 0;
        run_cycle(x, "tmo after");
        chk("tmo after state", 64'({ctrl_state, fence_timeout}), 64'b000);

        // simultaneous stall and branch error: hold only
        run_cycle(mk(1,0,0,1,32'h124,0,0,0,0), "stall+bpe");
        chk("stall+bpe", 64'({fe2de_hold, fe_redirect, fe2de_flush}), 64'b100);

        // reset in the middle of a FENCE
        x = mk(0,0,0,0,0,1,0,0,1); x.pc = 32'h40;
        run_cycle(x, "rstf enter");
        x = idle(); x.lsu = 0;
        run_cycle(x, "rstf drain");
        run_cycle(x, "rstf drain");
        #2;
        drive(idle());
        rst_n = 1'b0;
        #1;
        chk("rstf ctl", 64'(act_ctl()), 64'h0);
        chk("rstf rpc", 64'(fe_redirect_pc), 64'h0);
        chk("rstf stall_cnt", 64'(stall_cnt), 64'h0);
        #1 rst_n = 1'b1;
        model_reset();
        run_cycle(idle(), "rstf after");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            x = idle();
            x.ld    = ($urandom % 8) == 0;
            x.slc   = ($urandom % 12) == 0;
            x.md    = ($urandom % 7) == 0;
            x.lsu   = ($urandom % 2) == 0;
            x.bpe   = ($urandom % 6) == 0;
            x.tgt   = $urandom;
            x.valid = ($urandom % 4) != 0;
            x.exp   = ($urandom % 12) == 0;
            x.mret  = ($urandom % 12) == 0;
            x.fence = ($urandom % 6) == 0;
            x.rv16  = ($urandom % 2) == 0;
            x.pc    = $urandom;
            x.mtvec = $urandom;
            x.mepc  = $urandom;
            run_cycle(x, $sformatf("rnd%0d", i));
        end

        // saturation of the stall counter
        for (int i = 0; i < SMAX + 5; i++) run_cycle(mk(1,0,0,0,0,0,0,0,0), "sat");
        run_cycle(idle(), "sat end");
        chk("stall_cnt saturated", 64'(stall_cnt), 64'(SMAX));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
